// File: rtl/nco_adsr_envelope.sv
// ADSR amplitude envelope applied to the offset-binary NCO sample stream.
// The envelope advances once per TICK_DIV clocks. Gate edges act on the very
// next clock and take priority over a coincident tick. The output path is a
// two-stage pipeline: a signed multiply stage, then a rescale stage that
// re-centres the result on midscale.
module nco_adsr_envelope #(
    parameter int BIT_DEPTH = 12,
    parameter int ENV_W     = 16,
    parameter int TICK_DIV  = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gate,
    input  logic [ENV_W-1:0]     attack_step,
    input  logic [ENV_W-1:0]     decay_step,
    input  logic [ENV_W-1:0]     sustain_level,
    input  logic [ENV_W-1:0]     release_step,
    input  logic [BIT_DEPTH-1:0] sample_in,
    output logic [BIT_DEPTH-1:0] sample_out,
    output logic [ENV_W-1:0]     env_out,
    output logic [2:0]           state_out,
    output logic                 busy
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW    = BIT_DEPTH + ENV_W + 2;
    localparam logic [BIT_DEPTH-1:0] MID     = {1'b1, {(BIT_DEPTH-1){1'b0}}};
    localparam logic [ENV_W-1:0]     ENV_MAX = {ENV_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t            state, state_next;
    logic [ENV_W-1:0]  env, env_next;
    logic [CNT_W-1:0]  cnt;
    logic              gate_d;
    logic              tick, rise, fall;
    logic [ENV_W:0]    att_sum;
    logic signed [ENV_W:0] dec_diff;
    logic signed [BIT_DEPTH:0] d;
    logic signed [PW-1:0]      p;

    assign tick      = (cnt == CNT_W'(TICK_DIV - 1));
    assign rise      = gate & ~gate_d;
    assign fall      = ~gate & gate_d;
    assign att_sum   = {1'b0, env} + {1'b0, attack_step};
    assign dec_diff  = $signed({1'b0, env}) - $signed({1'b0, decay_step});
    assign d         = $signed({1'b0, sample_in} - {1'b0, MID});
    assign env_out   = env;
    assign state_out = state;
    assign busy      = (state != IDLE);

    // Free-running prescaler and gate edge register; gate edges never reset it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            gate_d <= 1'b0;
        end else begin
            cnt    <= tick ? '0 : cnt + 1'b1;
            gate_d <= gate;
        end
    end

    // Envelope state and level registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            env   <= '0;
        end else begin
            state <= state_next;
            env   <= env_next;
        end
    end

    // Next state: gate edges first (env kept), otherwise per-tick stage update.
    always_comb begin
        state_next = state;
        env_next   = env;
        if (rise) begin
            state_next = ATTACK;
        end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
            state_next = RELEASE;
        end else if (fall) begin
            state_next = state;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    env_next = '0;
                end
                ATTACK: begin
                    if (attack_step == '0 || att_sum >= {1'b0, ENV_MAX}) begin
                        env_next   = ENV_MAX;
                        state_next = DECAY;
                    end else begin
                        env_next = att_sum[ENV_W-1:0];
                    end
                end
                DECAY: begin
                    if (decay_step == '0 || dec_diff <= $signed({1'b0, sustain_level})) begin
                        env_next   = sustain_level;
                        state_next = SUSTAIN;
                    end else begin
                        env_next = dec_diff[ENV_W-1:0];
                    end
                end
                SUSTAIN: begin
                    env_next = sustain_level;
                end
                RELEASE: begin
                    if (release_step == '0 || env <= release_step) begin
                        env_next   = '0;
                        state_next = IDLE;
                    end else begin
                        env_next = env - release_step;
                    end
                end
                default: begin
                    env_next   = '0;
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Stage 1: signed (sample - midscale) times unsigned envelope.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p <= '0;
        end else begin
            p <= PW'(d) * PW'($signed({1'b0, env}));
        end
    end

    // Stage 2: floor-rescale by 2^ENV_W and re-centre; magnitude never exceeds midscale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_out <= MID;
        end else begin
            sample_out <= MID + BIT_DEPTH'(p >>> ENV_W);
        end
    end

endmodule
